// File: rtl/adder_pipe_n_pkg.sv
// Shared definitions for the segmented pipelined adder: operation modes and
// the segment-width computation.
package adder_pipe_n_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_pipe_n_seg.sv
// Combinational SEG-bit adder slice with carry in and carry out; one instance
// per pipeline stage.
module adder_seg #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/adder_pipe_n.sv
// Pipelined WIDTH-bit add/subtract unit: one SEG-bit segment is added per stage,
// with the carry registered between stages and valid/ready flow control.
module adder_pipe_n
    import adder_pipe_n_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned SEG  = seg_width(WIDTH, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    if (WIDTH % STAGES != 0) begin : g_bad_width
        $error("adder_pipe_n: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
    end

    // Operands travel rotated right one segment per stage, so the segment to be
    // added is always in the low SEG bits; finished sum segments enter at the top
    // of x and the last stage leaves exactly {s[STAGES-1], ..., s[0]} in x.
    logic [WIDTH-1:0] x_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic             c_in  [STAGES];
    logic             v_in  [STAGES];
    logic [SEG-1:0]   seg_s [STAGES];
    logic             seg_co[STAGES];
    logic [WIDTH-1:0] x_nxt [STAGES];
    logic [WIDTH-1:0] b_nxt [STAGES];

    logic [WIDTH-1:0] x_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];
    logic             ovf_nxt;
    logic             ovf_q;
    logic             en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_src
            assign x_in[k] = A;
            assign b_in[k] = (sub == MODE_ADD) ? B : ~B;
            assign c_in[k] = (sub == MODE_SUB) ? 1'b1 : Cin;
            assign v_in[k] = in_valid;
        end else begin : g_src
            assign x_in[k] = x_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign v_in[k] = v_q[k-1];
        end

        adder_seg #(.SEG(SEG)) u_seg (
            .a  (x_in[k][SEG-1:0]),
            .b  (b_in[k][SEG-1:0]),
            .ci (c_in[k]),
            .s  (seg_s[k]),
            .co (seg_co[k])
        );

        if (STAGES == 1) begin : g_rot
            assign x_nxt[k] = seg_s[k];
            assign b_nxt[k] = b_in[k];
        end else begin : g_rot
            assign x_nxt[k] = {seg_s[k], x_in[k][WIDTH-1:SEG]};
            assign b_nxt[k] = {b_in[k][SEG-1:0], b_in[k][WIDTH-1:SEG]};
        end
    end

    // The last stage sees the operand MSBs at the top of its low segment.
    assign ovf_nxt = (x_in[LAST][SEG-1] == b_in[LAST][SEG-1]) &&
                     (seg_s[LAST][SEG-1] != x_in[LAST][SEG-1]);

    assign en        = !v_q[LAST] || out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[LAST];
    assign Sum       = x_q[LAST];
    assign Cout      = c_q[LAST];
    assign Ovf       = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                x_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                x_q[k] <= x_nxt[k];
                b_q[k] <= b_nxt[k];
                c_q[k] <= seg_co[k];
                v_q[k] <= v_in[k];
            end
            ovf_q <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_adder_pipe_n.sv
// Self-checking bench for adder_pipe_n: directed vectors, streaming, stall,
// reset flush, latency at STAGES=1/16 and a long randomized run vs a model.
module tb_adder_pipe_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] A, B, Sum;
    logic        Cin, sub, Cout, Ovf;

    logic        p_valid, p_ready, p_Cin, p_sub;
    logic [15:0] p_A, p_B;
    logic        d1_in_ready, d1_out_valid, d1_Cout, d1_Ovf;
    logic [15:0] d1_Sum;
    logic        d16_in_ready, d16_out_valid, d16_Cout, d16_Ovf;
    logic [15:0] d16_Sum;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    adder_pipe_n #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    adder_pipe_n #(.WIDTH(16), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(d1_in_ready),
        .A(p_A), .B(p_B), .Cin(p_Cin), .sub(p_sub),
        .out_valid(d1_out_valid), .out_ready(p_ready),
        .Sum(d1_Sum), .Cout(d1_Cout), .Ovf(d1_Ovf)
    );

    adder_pipe_n #(.WIDTH(16), .STAGES(16)) dut_s16 (
        .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(d16_in_ready),
        .A(p_A), .B(p_B), .Cin(p_Cin), .sub(p_sub),
        .out_valid(d16_out_valid), .out_ready(p_ready),
        .Sum(d16_Sum), .Cout(d16_Cout), .Ovf(d16_Ovf)
    );

    // Reference: plain unsigned and signed integer arithmetic, packed {Cout, Ovf, Sum}.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic s);
        int unsigned ua, ub, u;
        int          sa, sb, sv;
        logic [15:0] r;
        logic        co, ov;
        ua = 32'(a);
        ub = 32'(b);
        sa = $signed(a);
        sb = $signed(b);
        u  = s ? ua + 32'd65536 - ub : ua + ub + 32'(ci);
        sv = s ? sa - sb : sa + sb + int'(ci);
        r  = u[15:0];
        co = u[16];
        ov = (sv > 32767) || (sv < -32768);
        return {co, ov, r};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            4:       return 16'h00FF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard for the STAGES=4 unit: transfers happen on the next rising edge.
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'({Cout, Ovf, Sum}), 32'(e));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(A, B, Cin, sub));
        end
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic drain(input string name);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check(name, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] ov;
        logic [17:0] exp1, got1, got16;
        int          n, lat1, lat16, cnt, acc, cyc;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[3] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        tbl[5] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[6] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        p_valid = 1'b0; p_ready = 1'b1; p_A = '0; p_B = '0; p_Cin = 1'b0; p_sub = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({Cout, Ovf, Sum}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_s1_s16_valid", 32'({d1_out_valid, d16_out_valid}), 32'd0);

        // Directed vectors, one at a time through an empty pipe.
        for (int i = 0; i < 8; i++) begin
            A = tbl[i].a; B = tbl[i].b; Cin = tbl[i].cin; sub = tbl[i].sub;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check("tbl_latency", 32'(n), 32'd4);
            check($sformatf("tbl%0d", i), 32'({Cout, Ovf, Sum}),
                  32'({tbl[i].cout, tbl[i].ovf, tbl[i].sum}));
            @(posedge clk); #1;
        end

        // Latency at STAGES=1 and STAGES=16.
        for (int i = 0; i < 3; i++) begin
            p_A = pick(); p_B = pick(); p_Cin = 1'($urandom); p_sub = 1'($urandom);
            exp1 = model(p_A, p_B, p_Cin, p_sub);
            p_valid = 1'b1;
            @(posedge clk); #1;
            p_valid = 1'b0;
            lat1 = 0; lat16 = 0; got1 = '0; got16 = '0;
            for (int k = 1; k <= 40; k++) begin
                if (d1_out_valid && lat1 == 0) begin
                    lat1 = k; got1 = {d1_Cout, d1_Ovf, d1_Sum};
                end
                if (d16_out_valid && lat16 == 0) begin
                    lat16 = k; got16 = {d16_Cout, d16_Ovf, d16_Sum};
                end
                @(posedge clk); #1;
            end
            check("s1_latency", 32'(lat1), 32'd1);
            check("s16_latency", 32'(lat16), 32'd16);
            check("s1_value", 32'(got1), 32'(exp1));
            check("s16_value", 32'(got16), 32'(exp1));
        end

        // Eight back-to-back ops: results on eight consecutive cycles.
        ov = '0;
        for (int i = 0; i < 16; i++) begin
            in_valid = (i < 8);
            A = pick(); B = pick(); Cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            ov[i] = out_valid;
        end
        in_valid = 1'b0;
        check("stream_pattern", 32'(ov), 32'h0000_07F8);
        drain("stream_drain");

        // Three-cycle consumer stall in the middle of a stream.
        for (int i = 0; i < 16; i++) begin
            in_valid  = (i < 12);
            A = pick(); B = pick(); Cin = 1'($urandom); sub = 1'($urandom);
            out_ready = !(i >= 6 && i <= 8);
            #1;
            if (i >= 6 && i <= 8) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                if (exp_q.size() != 0)
                    check("stall_hold", 32'({out_valid, Cout, Ovf, Sum}), 32'({1'b1, exp_q[0]}));
                else
                    check("stall_queue_empty", 32'(exp_q.size()), 32'd1);
            end
            @(posedge clk); #1;
        end
        drain("stall_drain");

        // Reset with three ops in flight.
        for (int i = 0; i < 3; i++) begin
            A = pick(); B = pick(); Cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cnt += int'(out_valid);
            @(posedge clk); #1;
        end
        check("flush_no_output", 32'(cnt), 32'd0);
        A = tbl[5].a; B = tbl[5].b; Cin = tbl[5].cin; sub = tbl[5].sub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("flush_new_latency", 32'(n), 32'd4);
        check("flush_new_value", 32'({Cout, Ovf, Sum}),
              32'({tbl[5].cout, tbl[5].ovf, tbl[5].sum}));
        drain("flush_drain");

        // Long randomized run with random bubbles and backpressure.
        acc = 0; cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            A = pick(); B = pick(); Cin = 1'($urandom); sub = 1'($urandom);
            #1;
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        check("random_accepted", 32'(acc), 32'd10000);
        drain("random_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
